// File: rtl/mux_rr_scheduler.sv
// mux_rr_scheduler: two-lane round-robin byte scheduler with per-lane FIFOs and a registered, lane-tagged output stage.
module mux_rr_scheduler #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in_0,
    input  logic              valid_in_0,
    output logic              ready_0,
    input  logic [DATA_W-1:0] data_in_1,
    input  logic              valid_in_1,
    output logic              ready_1,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              lane_out,
    input  logic              ready_out,
    output logic [CNT_W-1:0]  count_0,
    output logic [CNT_W-1:0]  count_1
);
    localparam int PW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_0 [DEPTH];
    logic [DATA_W-1:0] mem_1 [DEPTH];
    logic [PW-1:0]     wr_ptr_0, rd_ptr_0, wr_ptr_1, rd_ptr_1;
    logic              last_grant;
    logic              push_0, push_1, pop_0, pop_1;
    logic              ne_0, ne_1, load_en, grant_en, grant;

    // Emptiness and fullness come from registered counts only, so a push is never granted in its own cycle.
    always_comb begin
        ready_0  = count_0 < CNT_W'(DEPTH);
        ready_1  = count_1 < CNT_W'(DEPTH);
        push_0   = valid_in_0 && ready_0;
        push_1   = valid_in_1 && ready_1;
        ne_0     = count_0 != '0;
        ne_1     = count_1 != '0;
        load_en  = !valid_out || ready_out;
        grant_en = load_en && (ne_0 || ne_1);
        grant    = (ne_0 && ne_1) ? ~last_grant : ne_1;
        pop_0    = grant_en && !grant;
        pop_1    = grant_en && grant;
    end

    always_ff @(posedge clk) begin
        if (push_0) mem_0[wr_ptr_0] <= data_in_0;
        if (push_1) mem_1[wr_ptr_1] <= data_in_1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_0   <= '0;
            rd_ptr_0   <= '0;
            wr_ptr_1   <= '0;
            rd_ptr_1   <= '0;
            count_0    <= '0;
            count_1    <= '0;
            valid_out  <= 1'b0;
            data_out   <= '0;
            lane_out   <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (push_0) wr_ptr_0 <= wr_ptr_0 + PW'(1);
            if (push_1) wr_ptr_1 <= wr_ptr_1 + PW'(1);
            if (pop_0) rd_ptr_0 <= rd_ptr_0 + PW'(1);
            if (pop_1) rd_ptr_1 <= rd_ptr_1 + PW'(1);
            count_0 <= count_0 + CNT_W'(push_0) - CNT_W'(pop_0);
            count_1 <= count_1 + CNT_W'(push_1) - CNT_W'(pop_1);
            if (load_en) valid_out <= grant_en;
            if (grant_en) begin
                data_out   <= grant ? mem_1[rd_ptr_1] : mem_0[rd_ptr_0];
                lane_out   <= grant;
                last_grant <= grant;
            end
        end
    end
endmodule

// File: tb/tb_mux_rr_scheduler.sv
// tb_mux_rr_scheduler: checks the scheduler against a queue-based reference and per-lane scoreboards.
module tb_mux_rr_scheduler;
    localparam int DEPTH = 4;

    logic       clk = 0, reset = 1;
    logic [7:0] data_in_0 = 0, data_in_1 = 0, data_out;
    logic       valid_in_0 = 0, valid_in_1 = 0, ready_0, ready_1;
    logic       valid_out, lane_out, ready_out = 0;
    logic [2:0] count_0, count_1;

    mux_rr_scheduler dut (
        .clk(clk), .reset(reset),
        .data_in_0(data_in_0), .valid_in_0(valid_in_0), .ready_0(ready_0),
        .data_in_1(data_in_1), .valid_in_1(valid_in_1), .ready_1(ready_1),
        .data_out(data_out), .valid_out(valid_out), .lane_out(lane_out),
        .ready_out(ready_out), .count_0(count_0), .count_1(count_1)
    );

    always #5 clk = ~clk;

    typedef struct { logic v0; logic [7:0] d0; logic vo; logic chk_d; logic [7:0] dout; } vec_t;
    typedef struct { logic [7:0] d; logic l; } out_t;

    int total = 0, bad = 0;
    logic [7:0] q0[$], q1[$], sb0[$], sb1[$];
    out_t       obs[$];
    logic       m_vo = 0, m_lo = 0, m_lg = 1;
    logic [7:0] m_do = 0;
    logic       prev_stall = 0, prev_l = 0;
    logic [7:0] prev_d = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Compare against the reference model and drain the scoreboard on every accepted output byte.
    task automatic sample();
        logic [7:0] e;
        @(negedge clk);
        chk("valid_out", valid_out, m_vo);
        chk("data_out", data_out, m_do);
        chk("lane_out", lane_out, m_lo);
        chk("count_0", count_0, q0.size());
        chk("count_1", count_1, q1.size());
        chk("ready_0", ready_0, q0.size() < DEPTH);
        chk("ready_1", ready_1, q1.size() < DEPTH);
        if (prev_stall) begin
            chk("stall_data", data_out, prev_d);
            chk("stall_lane", lane_out, prev_l);
        end
        prev_stall = valid_out && !ready_out && !reset;
        prev_d = data_out;
        prev_l = lane_out;
        if (valid_out && ready_out && !reset) begin
            obs.push_back('{data_out, lane_out});
            if ((lane_out ? sb1.size() : sb0.size()) == 0) chk("sb_unexpected", data_out, 0);
            else begin
                e = lane_out ? sb1.pop_front() : sb0.pop_front();
                chk("sb_data", data_out, e);
            end
        end
    endtask

    task automatic advance();
        logic p0, p1, n0, n1, g;
        if (reset) begin
            q0 = {}; q1 = {}; sb0 = {}; sb1 = {};
            m_vo = 0; m_do = 0; m_lo = 0; m_lg = 1; prev_stall = 0;
        end else begin
            p0 = valid_in_0 && q0.size() < DEPTH;
            p1 = valid_in_1 && q1.size() < DEPTH;
            if (!m_vo || ready_out) begin
                n0 = q0.size() > 0;
                n1 = q1.size() > 0;
                if (n0 || n1) begin
                    g = (n0 && n1) ? !m_lg : n1;
                    m_do = g ? q1.pop_front() : q0.pop_front();
                    m_lo = g; m_vo = 1; m_lg = g;
                end else m_vo = 0;
            end
            if (p0) begin q0.push_back(data_in_0); sb0.push_back(data_in_0); end
            if (p1) begin q1.push_back(data_in_1); sb1.push_back(data_in_1); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic do_reset();
        reset = 1; valid_in_0 = 0; valid_in_1 = 0;
        advance();
        reset = 0;
    endtask

    vec_t vecs[6];
    out_t cont[8];

    initial begin
        vecs[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 8'h00};
        vecs[2] = '{1'b1, 8'h33, 1'b1, 1'b1, 8'h11};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h22};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h33};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h33};
        for (int i = 0; i < 4; i++) begin
            cont[2*i]   = '{8'hA0 + 8'(i), 1'b0};
            cont[2*i+1] = '{8'hB0 + 8'(i), 1'b1};
        end

        advance();
        do_reset();
        // reset then idle
        for (int i = 0; i < 3; i++) tick();
        chk("idle_ready_0", ready_0, 1);
        chk("idle_valid", valid_out, 0);

        // lane 0 only
        ready_out = 1;
        for (int i = 0; i < 6; i++) begin
            valid_in_0 = vecs[i].v0; data_in_0 = vecs[i].d0;
            sample();
            chk("vec_valid", valid_out, vecs[i].vo);
            if (vecs[i].chk_d) begin
                chk("vec_data", data_out, vecs[i].dout);
                chk("vec_lane", lane_out, 0);
            end
            advance();
        end

        // contention
        ready_out = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            valid_in_0 = 1; data_in_0 = 8'hA0 + 8'(i);
            valid_in_1 = 1; data_in_1 = 8'hB0 + 8'(i);
            tick();
        end
        valid_in_0 = 0; valid_in_1 = 0;
        sample();
        chk("cont_count_1", count_1, 4);
        chk("cont_ready_1", ready_1, 0);
        advance();
        ready_out = 1;
        obs = {};
        for (int i = 0; i < 10; i++) tick();
        chk("cont_len", obs.size(), 8);
        for (int i = 0; i < 8 && i < obs.size(); i++) begin
            chk("cont_data", obs[i].d, cont[i].d);
            chk("cont_lane", obs[i].l, cont[i].l);
        end

        // backpressure during a stream
        for (int i = 0; i < 14; i++) begin
            ready_out = (i % 4 == 0) || (i % 4 == 3);
            valid_in_0 = i < 8; data_in_0 = 8'h40 + 8'(i);
            tick();
        end
        valid_in_0 = 0; ready_out = 1;
        for (int i = 0; i < 4; i++) tick();
        chk("bp_drained", sb0.size(), 0);

        // full boundary on lane 1
        ready_out = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            valid_in_1 = 1; data_in_1 = 8'hC0 + 8'(i);
            tick();
        end
        valid_in_1 = 0;
        sample();
        chk("full_count_1", count_1, 4);
        chk("full_ready_1", ready_1, 0);
        advance();
        ready_out = 1; valid_in_1 = 1; data_in_1 = 8'hCC;
        tick();
        sample();
        chk("full_reject_count", count_1, 3);
        chk("full_pop_data", data_out, 8'hC1);
        advance();
        valid_in_1 = 0;
        sample();
        chk("full_late_count", count_1, 3);
        advance();
        for (int i = 0; i < 6; i++) tick();
        chk("full_drained", sb1.size(), 0);

        // reset mid-stream
        ready_out = 0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            valid_in_0 = 1; data_in_0 = 8'h60 + 8'(i);
            valid_in_1 = i < 2; data_in_1 = 8'h70 + 8'(i);
            tick();
        end
        valid_in_0 = 0; valid_in_1 = 0;
        sample();
        chk("mid_valid_pre", valid_out, 1);
        chk("mid_count_0_pre", count_0, 2);
        chk("mid_count_1_pre", count_1, 2);
        reset = 1;
        advance();
        reset = 0;
        sample();
        chk("mid_valid_post", valid_out, 0);
        chk("mid_count_0_post", count_0, 0);
        chk("mid_count_1_post", count_1, 0);
        advance();
        ready_out = 1;
        valid_in_0 = 1; data_in_0 = 8'h81;
        valid_in_1 = 1; data_in_1 = 8'h91;
        tick();
        valid_in_0 = 0; valid_in_1 = 0;
        tick();
        sample();
        chk("post_first_valid", valid_out, 1);
        chk("post_first_lane", lane_out, 0);
        chk("post_first_data", data_out, 8'h81);
        advance();
        for (int i = 0; i < 3; i++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
